ysyx_041514_icache_refill: RTL and testbench
============================================

// Module: ysyx_041514_icache_refill
// PURPOSE
//  Write-side engine for the icache data array: on a miss, issues one AXI4 INCR read
//  burst for a 64-byte line, turns each 64-bit R beat into a masked 128-bit SRAM write
//  (index, burst_count, wmask, wen), then pulses the tag write and done to the icache FSM.
//  Sits between the icache controller and the AXI read master port.
// PARAMETERS
//  IDX_LEN   6   set index width; drives icache_index_o
//  BLK_LEN   6   line offset width; line = 2^BLK_LEN bytes = 8 beats of 64 bits
//  TAG_LEN   20  tag width = 32 - IDX_LEN - BLK_LEN
// PORTS
//  clk                  in   1        clock
//  rst                  in   1        synchronous reset, active-low
//  refill_req_i         in   1        start refill; sampled only in IDLE
//  refill_addr_i        in   32       miss address; low BLK_LEN bits ignored
//  refill_busy_o        out  1        high in any state other than IDLE
//  refill_done_o        out  1        1-cycle pulse: line fully written
//  refill_err_o         out  1        valid with done: any beat had rresp!=0 or bad rlast
//  arvalid_o/arready_i  out/in 1      AXI AR handshake
//  araddr_o             out  32       {refill_addr_i[31:BLK_LEN], BLK_LEN'b0}
//  arlen_o              out  8        constant 8'd7
//  arsize_o/arburst_o   out  3/2      constant 3'b011 / 2'b01 (INCR)
//  rvalid_i/rready_o    in/out 1      AXI R handshake
//  rdata_i              in   64       beat data
//  rresp_i              in   2        beat response
//  rlast_i              in   1        last beat flag
//  icache_index_o       out  IDX_LEN  set index, held for whole refill
//  icache_line_wdata_o  out  128      {rdata_i, rdata_i}
//  icache_wmask_o       out  128      beat[0]=0: low 64 ones; beat[0]=1: high 64 ones
//  burst_count_o        out  3        beat number 0..7; [2:1] selects SRAM bank
//  icache_wen_o         out  1        data array write enable
//  tag_wen_o            out  1        1-cycle tag/valid write pulse
//  tag_o                out  TAG_LEN  refill_addr_i[31:IDX_LEN+BLK_LEN], latched
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, beat counter=0, err flag=0; arvalid_o, rready_o,
//   icache_wen_o, tag_wen_o, refill_done_o, refill_err_o, refill_busy_o all 0.
//  FSM IDLE -> AR -> R -> DONE -> IDLE.
//  IDLE: refill_req_i=1 latches araddr/index/tag, clears counter+err flag, next=AR.
//  AR: arvalid_o=1, address stable; arready_i=1 -> R. arvalid never drops before handshake.
//  R: rready_o=1. Beat accepted when rvalid_i&rready_o: same cycle icache_wen_o=1,
//   burst_count_o=counter, wmask/wdata per counter[0]; counter increments mod 8.
//   rresp_i!=0 sets err flag (sticky); beats still consumed and written.
//   rlast_i on counter==7 -> DONE. rlast_i on counter<7, or counter==7 without rlast_i,
//   sets err flag; exit to DONE only on rlast_i (extra beats counted modulo 8, written).
//  DONE (one cycle): refill_done_o=1, refill_err_o=err flag, tag_wen_o=~err flag; next=IDLE.
//  icache_wen_o is 0 outside accepted R beats; no write on rvalid_i with state!=R.
//  refill_req_i ignored while busy; a request held high in DONE is taken in following IDLE.
//  Earliest refill: req at cycle 0, AR at 1, first beat at 2, done at 10 (zero-wait slave).
//  Reset mid-burst: immediate return to IDLE, pending AXI txn abandoned (system-reset only).
// TESTING
//  req addr 0x8000_1234, arready=1, 8 back-to-back beats D0..D7 -> araddr 0x8000_1200,
//   arlen 7, index 0x08, tag 0x80001; wen 8 cycles, burst_count 0..7, done+tag_wen 1 cycle.
//  beat 3 data 0xDEAD_BEEF_0123_4567 -> wdata both halves equal it, wmask high 64 ones, bc=3.
//  arready delayed 5 cycles, rvalid toggled 1/0 -> arvalid held, wen only on valid beats,
//   burst_count still 0..7 in order, done once.
//  rresp=2'b10 on beat 5 -> all 8 beats written, done with err=1, tag_wen=0.
//  rlast on beat 4 -> DONE after beat 4, err=1, tag_wen=0, back to IDLE.
//  rst low after beat 2 -> next cycle IDLE, all outputs 0; new req completes normally.

Source files
------------

// File: rtl/ysyx_041514_icache_refill.sv
// ysyx_041514_icache_refill
// Refill engine for the icache data array. On a miss it issues one AXI4 INCR
// read burst for a whole line and turns every accepted 64-bit R beat into a
// masked 128-bit SRAM write. When the line is complete it pulses the tag write
// and done signals back to the icache controller.

module ysyx_041514_icache_refill #(
    parameter int IDX_LEN = 6,
    parameter int BLK_LEN = 6,
    parameter int TAG_LEN = 32 - IDX_LEN - BLK_LEN
) (
    input  logic               clk,
    input  logic               rst,
    // icache controller side
    input  logic               refill_req_i,
    input  logic [31:0]        refill_addr_i,
    output logic               refill_busy_o,
    output logic               refill_done_o,
    output logic               refill_err_o,
    // AXI AR channel
    output logic               arvalid_o,
    input  logic               arready_i,
    output logic [31:0]        araddr_o,
    output logic [7:0]         arlen_o,
    output logic [2:0]         arsize_o,
    output logic [1:0]         arburst_o,
    // AXI R channel
    input  logic               rvalid_i,
    output logic               rready_o,
    input  logic [63:0]        rdata_i,
    input  logic [1:0]         rresp_i,
    input  logic               rlast_i,
    // data array write port
    output logic [IDX_LEN-1:0] icache_index_o,
    output logic [127:0]       icache_line_wdata_o,
    output logic [127:0]       icache_wmask_o,
    output logic [2:0]         burst_count_o,
    output logic               icache_wen_o,
    // tag array write port
    output logic               tag_wen_o,
    output logic [TAG_LEN-1:0] tag_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  count_q, count_d;
    logic        err_q, err_d;

    logic        beat_fire;

    // A beat is only consumed while collecting the burst.
    assign beat_fire = (state_q == ST_R) && rvalid_i;

    // State register; the active-low reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            count_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: latch the line address, count beats, collect errors.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (refill_req_i) begin
                    addr_d  = {refill_addr_i[31:BLK_LEN], {BLK_LEN{1'b0}}};
                    count_d = 3'd0;
                    err_d   = 1'b0;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (arready_i) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (beat_fire) begin
                    // Bad response, early rlast or a missing rlast on beat 7
                    // all poison the line; extra beats wrap the counter.
                    if (rresp_i != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (rlast_i != (count_q == 3'd7)) begin
                        err_d = 1'b1;
                    end
                    count_d = count_q + 3'd1;
                    if (rlast_i) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        refill_busy_o = (state_q != ST_IDLE);
        arvalid_o     = (state_q == ST_AR);
        rready_o      = (state_q == ST_R);
        icache_wen_o  = beat_fire;
        refill_done_o = (state_q == ST_DONE);
        refill_err_o  = (state_q == ST_DONE) && err_q;
        tag_wen_o     = (state_q == ST_DONE) && !err_q;
    end

    assign araddr_o       = addr_q;
    assign arlen_o        = 8'd7;
    assign arsize_o       = 3'b011;
    assign arburst_o      = 2'b01;
    assign icache_index_o = addr_q[IDX_LEN+BLK_LEN-1:BLK_LEN];
    assign tag_o          = addr_q[31:IDX_LEN+BLK_LEN];
    assign burst_count_o  = count_q;

    // Each beat fills one 64-bit half of a 128-bit SRAM word; even beats go
    // low, odd beats go high. Data is replicated so the mask alone selects.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign icache_line_wdata_o[gi*64 +: 64] = rdata_i;
            assign icache_wmask_o[gi*64 +: 64]      = {64{count_q[0] == gi[0]}};
        end
    endgenerate

endmodule

// File: tb/tb_ysyx_041514_icache_refill.sv
// tb_ysyx_041514_icache_refill
// Directed bench for the icache refill engine with a hand-driven AXI slave.

module tb_ysyx_041514_icache_refill;

    logic         clk;
    logic         rst;
    logic         refill_req_i;
    logic [31:0]  refill_addr_i;
    logic         refill_busy_o;
    logic         refill_done_o;
    logic         refill_err_o;
    logic         arvalid_o;
    logic         arready_i;
    logic [31:0]  araddr_o;
    logic [7:0]   arlen_o;
    logic [2:0]   arsize_o;
    logic [1:0]   arburst_o;
    logic         rvalid_i;
    logic         rready_o;
    logic [63:0]  rdata_i;
    logic [1:0]   rresp_i;
    logic         rlast_i;
    logic [5:0]   icache_index_o;
    logic [127:0] icache_line_wdata_o;
    logic [127:0] icache_wmask_o;
    logic [2:0]   burst_count_o;
    logic         icache_wen_o;
    logic         tag_wen_o;
    logic [19:0]  tag_o;

    int errors = 0;
    int checks = 0;

    ysyx_041514_icache_refill dut (
        .clk                 (clk),
        .rst                 (rst),
        .refill_req_i        (refill_req_i),
        .refill_addr_i       (refill_addr_i),
        .refill_busy_o       (refill_busy_o),
        .refill_done_o       (refill_done_o),
        .refill_err_o        (refill_err_o),
        .arvalid_o           (arvalid_o),
        .arready_i           (arready_i),
        .araddr_o            (araddr_o),
        .arlen_o             (arlen_o),
        .arsize_o            (arsize_o),
        .arburst_o           (arburst_o),
        .rvalid_i            (rvalid_i),
        .rready_o            (rready_o),
        .rdata_i             (rdata_i),
        .rresp_i             (rresp_i),
        .rlast_i             (rlast_i),
        .icache_index_o      (icache_index_o),
        .icache_line_wdata_o (icache_line_wdata_o),
        .icache_wmask_o      (icache_wmask_o),
        .burst_count_o       (burst_count_o),
        .icache_wen_o        (icache_wen_o),
        .tag_wen_o           (tag_wen_o),
        .tag_o               (tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input int b);
        logic [63:0] d;
        if (b == 3) d = 64'hDEAD_BEEF_0123_4567;
        else        d = {32'hD0D0_D0D0, 32'(b)};
        return d;
    endfunction

    // Everything the controller sees while idle must be quiet.
    task automatic check_idle(input string tag);
        check_eq({tag, ".busy"},    128'(refill_busy_o), 128'd0);
        check_eq({tag, ".arvalid"}, 128'(arvalid_o),     128'd0);
        check_eq({tag, ".rready"},  128'(rready_o),      128'd0);
        check_eq({tag, ".wen"},     128'(icache_wen_o),  128'd0);
        check_eq({tag, ".tagwen"},  128'(tag_wen_o),     128'd0);
        check_eq({tag, ".done"},    128'(refill_done_o), 128'd0);
        check_eq({tag, ".err"},     128'(refill_err_o),  128'd0);
    endtask

    // Issue a request and play the AR handshake; returns in R state at edge+1.
    task automatic start_refill(input string tag, input logic [31:0] addr, input int ar_delay,
                                input logic [31:0] exp_araddr, input logic [5:0] exp_idx,
                                input logic [19:0] exp_tag);
        @(posedge clk); #1;
        refill_req_i  = 1'b1;
        refill_addr_i = addr;
        @(posedge clk); #1;
        refill_req_i  = 1'b0;
        refill_addr_i = 32'hFFFF_FFFF;
        #1;
        check_eq({tag, ".ar.busy"},   128'(refill_busy_o), 128'd1);
        check_eq({tag, ".araddr"},    128'(araddr_o),      128'(exp_araddr));
        check_eq({tag, ".arlen"},     128'(arlen_o),       128'd7);
        check_eq({tag, ".arsize"},    128'(arsize_o),      128'd3);
        check_eq({tag, ".arburst"},   128'(arburst_o),     128'd1);
        check_eq({tag, ".index"},     128'(icache_index_o), 128'(exp_idx));
        check_eq({tag, ".tag"},       128'(tag_o),         128'(exp_tag));
        for (int i = 0; i < ar_delay; i++) begin
            arready_i = 1'b0;
            rvalid_i  = 1'b1;  // stray R traffic outside R state must not write
            #1;
            check_eq({tag, ".ar.hold"},   128'(arvalid_o),    128'd1);
            check_eq({tag, ".ar.nowen"},  128'(icache_wen_o), 128'd0);
            check_eq({tag, ".ar.nordy"},  128'(rready_o),     128'd0);
            @(posedge clk); #1;
        end
        rvalid_i  = 1'b0;
        arready_i = 1'b1;
        #1;
        check_eq({tag, ".arvalid"}, 128'(arvalid_o), 128'd1);
        @(posedge clk); #1;
        arready_i = 1'b0;
    endtask

    // Serve n_beats beats (rlast on the final one), then check DONE.
    task automatic serve_beats(input string tag, input int n_beats, input bit toggle,
                               input int resp_beat, input bit exp_err);
        int beat = 0;
        int cyc  = 0;
        int wens = 0;
        bit vld;
        logic [127:0] exp_mask;
        while (beat < n_beats && cyc < 64) begin
            vld      = toggle ? (cyc % 2 == 0) : 1'b1;
            rvalid_i = vld;
            rdata_i  = beat_data(beat);
            rresp_i  = (beat == resp_beat) ? 2'b10 : 2'b00;
            rlast_i  = (beat == n_beats - 1);
            #1;
            check_eq({tag, ".rready"}, 128'(rready_o),     128'd1);
            check_eq({tag, ".wen"},    128'(icache_wen_o), 128'(vld));
            if (vld) begin
                exp_mask = (beat % 2 == 1) ? {{64{1'b1}}, 64'd0} : {64'd0, {64{1'b1}}};
                check_eq({tag, ".bc"},    128'(burst_count_o), 128'(beat % 8));
                check_eq({tag, ".wdata"}, icache_line_wdata_o, {beat_data(beat), beat_data(beat)});
                check_eq({tag, ".wmask"}, icache_wmask_o, exp_mask);
                beat++;
                wens++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({tag, ".beats_in_budget"}, 128'(beat), 128'(n_beats));
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        rresp_i  = 2'b00;
        #1;
        check_eq({tag, ".done"},   128'(refill_done_o), 128'd1);
        check_eq({tag, ".err"},    128'(refill_err_o),  128'(exp_err));
        check_eq({tag, ".tagwen"}, 128'(tag_wen_o),     128'(!exp_err));
        check_eq({tag, ".d.wen"},  128'(icache_wen_o),  128'd0);
        @(posedge clk); #1;
        check_idle({tag, ".post"});
        $display("%s: beats=%0d wen_cycles=%0d err=%0d", tag, n_beats, wens, exp_err);
    endtask

    initial begin
        rst           = 1'b0;
        refill_req_i  = 1'b0;
        refill_addr_i = 32'd0;
        arready_i     = 1'b0;
        rvalid_i      = 1'b0;
        rdata_i       = 64'd0;
        rresp_i       = 2'b00;
        rlast_i       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        check_eq("reset.bc", 128'(burst_count_o), 128'd0);
        rst = 1'b1;

        // Zero-wait slave, eight back-to-back beats.
        start_refill("basic", 32'h8000_1234, 0, 32'h8000_1200, 6'h08, 20'h80001);
        serve_beats("basic", 8, 1'b0, -1, 1'b0);

        // Slow AR, R valid toggling.
        start_refill("slow", 32'h1234_5678, 5, 32'h1234_5640, 6'h19, 20'h12345);
        serve_beats("slow", 8, 1'b1, -1, 1'b0);

        // Error response on beat 5.
        start_refill("resp", 32'h0000_0FC0, 0, 32'h0000_0FC0, 6'h3F, 20'h00000);
        serve_beats("resp", 8, 1'b0, 5, 1'b1);

        // Early rlast on beat 4.
        start_refill("early", 32'hA000_0040, 0, 32'hA000_0040, 6'h01, 20'hA0000);
        serve_beats("early", 5, 1'b0, -1, 1'b1);

        // Reset after beat 2, then a clean refill.
        start_refill("rst", 32'h8000_1234, 0, 32'h8000_1200, 6'h08, 20'h80001);
        for (int b = 0; b < 3; b++) begin
            rvalid_i = 1'b1;
            rdata_i  = beat_data(b);
            @(posedge clk); #1;
        end
        rvalid_i = 1'b0;
        rst      = 1'b0;
        @(posedge clk); #1;
        check_idle("midrst");
        check_eq("midrst.bc", 128'(burst_count_o), 128'd0);
        rst = 1'b1;
        $display("midrst: reset after 3 beats, engine idle");
        start_refill("after", 32'h8000_1234, 0, 32'h8000_1200, 6'h08, 20'h80001);
        serve_beats("after", 8, 1'b0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
